// File: rtl/mem_store_ctrl.sv
// Store sequencer for the multicycle datapath: sw writes directly, sh/sb do a
// read-modify-write of the containing word; misaligned or illegal requests end in ERR.
module mem_store_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] T_SW  = 2'b00;
  localparam logic [1:0] T_SH  = 2'b01;
  localparam logic [1:0] T_BAD = 2'b11;
  localparam logic [2:0] LAT_W = 3'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  // Replace the addressed byte/halfword lane of w with the low bits of d (little-endian).
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] t,
                                             input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (t == T_SH) begin
      if (a[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    type_d    = type_q;
    rd_buf_d  = rd_buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          data_d = write_data;
          type_d = store_type;
          if (store_type == T_BAD ||
              (store_type == T_SW && addr[1:0] != 2'b00) ||
              (store_type == T_SH && addr[0]))
            state_d = S_ERR;
          else if (store_type == T_SW)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        if (lat_cnt_q == LAT_W) begin
          rd_buf_d  = mem_rdata;
          lat_cnt_d = 3'd0;
          state_d   = S_WRITE;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed for the upcoming state so they come straight off flops.
    mem_wr_d    = (state_d == S_WRITE);
    mem_addr_d  = (state_d == S_READ || state_d == S_WRITE) ? {addr_d[31:2], 2'b00} : 32'd0;
    mem_wdata_d = 32'd0;
    if (state_d == S_WRITE)
      mem_wdata_d = (type_d == T_SW) ? data_d : merge_lane(rd_buf_d, type_d, addr_d[1:0], data_d);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE || state_d == S_ERR);
    misalign_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= 3'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      type_q      <= 2'b00;
      rd_buf_q    <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      type_q      <= type_d;
      rd_buf_q    <= rd_buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl: one instance with read latency 1, one with latency 3,
// each attached to a small word memory that returns junk until the read latency has elapsed.
module tb_mem_store_ctrl;

  logic        clk;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] write_data;

  logic [31:0] mem_rdata1, mem_addr1, mem_wdata1;
  logic        mem_wr1, busy1, done1, misalign1;
  logic [31:0] mem_rdata3, mem_addr3, mem_wdata3;
  logic        mem_wr3, busy3, done3, misalign3;

  int checks;
  int failures;

  mem_store_ctrl #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .store_type(store_type), .addr(addr),
    .write_data(write_data), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .busy(busy1), .done(done1), .misalign(misalign1)
  );

  mem_store_ctrl #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .store_type(store_type), .addr(addr),
    .write_data(write_data), .mem_rdata(mem_rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .busy(busy3), .done(done3), .misalign(misalign3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  int          rd_cnt1, rd_cnt3;
  int          wr_cnt1, wr_cnt3;
  logic        poke1, poke3;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  assign mem_rdata1 = (rd_cnt1 >= 1) ? mem1[mem_addr1[7:2]] : 32'hBAD0_BAD0;
  assign mem_rdata3 = (rd_cnt3 >= 3) ? mem3[mem_addr3[7:2]] : 32'hBAD0_BAD0;

  initial begin
    rd_cnt1 = 0; rd_cnt3 = 0; wr_cnt1 = 0; wr_cnt3 = 0;
  end

  always @(posedge clk) begin
    if (busy1 && !mem_wr1 && !done1) rd_cnt1 <= rd_cnt1 + 1;
    else rd_cnt1 <= 0;
    if (mem_wr1) begin
      mem1[mem_addr1[7:2]] <= mem_wdata1;
      wr_cnt1 <= wr_cnt1 + 1;
    end else if (poke1) begin
      mem1[poke_idx] <= poke_val;
    end
  end

  always @(posedge clk) begin
    if (busy3 && !mem_wr3 && !done3) rd_cnt3 <= rd_cnt3 + 1;
    else rd_cnt3 <= 0;
    if (mem_wr3) begin
      mem3[mem_addr3[7:2]] <= mem_wdata3;
      wr_cnt3 <= wr_cnt3 + 1;
    end else if (poke3) begin
      mem3[poke_idx] <= poke_val;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input bit sel3, input logic [5:0] idx, input logic [31:0] val);
    poke_idx = idx;
    poke_val = val;
    if (sel3) poke3 = 1'b1; else poke1 = 1'b1;
    @(posedge clk); #1;
    poke1 = 1'b0;
    poke3 = 1'b0;
  endtask

  // Presents a request to the latency-1 instance; returns #1 after the accepting edge (cycle 1).
  task automatic issue1(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    store_type = t;
    addr       = a;
    write_data = d;
    start1     = 1'b1;
    @(posedge clk); #1;
    start1     = 1'b0;
    store_type = 2'b11;
    addr       = 32'hFFFF_FFFF;
    write_data = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_addr1 !== 32'd0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr1); end
    checks++; if (mem_wdata1 !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata1); end
    checks++; if (mem_wr1 !== 1'b0) begin failures++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done1); end
    checks++; if (misalign1 !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b want 0", misalign1); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_sw();
    int wr0;
    wr0 = wr_cnt1;
    issue1(2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
    checks++; if (mem_wr1 !== 1'b1) begin failures++; $display("FAIL sw_wr_c1: got %b want 1", mem_wr1); end
    checks++; if (mem_addr1 !== 32'h10) begin failures++; $display("FAIL sw_addr_c1: got %h want 00000010", mem_addr1); end
    checks++; if (mem_wdata1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata_c1: got %h want deadbeef", mem_wdata1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sw_busy_c1: got %b want 1", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL sw_done_c1: got %b want 0", done1); end
    next_cycle();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL sw_done_c2: got %b want 1", done1); end
    checks++; if (misalign1 !== 1'b0) begin failures++; $display("FAIL sw_misalign_c2: got %b want 0", misalign1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sw_busy_c2: got %b want 1", busy1); end
    checks++; if (mem_wr1 !== 1'b0) begin failures++; $display("FAIL sw_wr_c2: got %b want 0", mem_wr1); end
    checks++; if (mem_wdata1 !== 32'd0) begin failures++; $display("FAIL sw_wdata_c2: got %h want 0", mem_wdata1); end
    next_cycle();
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL sw_idle_c3: got busy=%b done=%b want 0 0", busy1, done1); end
    checks++; if (wr_cnt1 !== wr0 + 1 || mem1[4] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_mem: got writes=%0d word=%h want %0d deadbeef", wr_cnt1 - wr0, mem1[4], 1); end
  endtask

  task automatic test_sb();
    int wr0;
    poke(1'b0, 6'd8, 32'h1122_3344);
    wr0 = wr_cnt1;
    issue1(2'b10, 32'h0000_0022, 32'hFFFF_FFAB);
    checks++; if (busy1 !== 1'b1 || mem_wr1 !== 1'b0 || mem_addr1 !== 32'h20) begin failures++; $display("FAIL sb_read_c1: got busy=%b wr=%b addr=%h want 1 0 00000020", busy1, mem_wr1, mem_addr1); end
    next_cycle();
    checks++; if (busy1 !== 1'b1 || mem_wr1 !== 1'b0 || mem_addr1 !== 32'h20) begin failures++; $display("FAIL sb_read_c2: got busy=%b wr=%b addr=%h want 1 0 00000020", busy1, mem_wr1, mem_addr1); end
    next_cycle();
    checks++; if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h20) begin failures++; $display("FAIL sb_write_c3: got wr=%b addr=%h want 1 00000020", mem_wr1, mem_addr1); end
    checks++; if (mem_wdata1 !== 32'h11AB_3344) begin failures++; $display("FAIL sb_wdata_c3: got %h want 11ab3344", mem_wdata1); end
    next_cycle();
    checks++; if (done1 !== 1'b1 || misalign1 !== 1'b0 || mem_wr1 !== 1'b0) begin failures++; $display("FAIL sb_done_c4: got done=%b mis=%b wr=%b want 1 0 0", done1, misalign1, mem_wr1); end
    next_cycle();
    checks++; if (wr_cnt1 !== wr0 + 1 || mem1[8] !== 32'h11AB_3344) begin failures++; $display("FAIL sb_mem: got writes=%0d word=%h want 1 11ab3344", wr_cnt1 - wr0, mem1[8]); end
  endtask

  task automatic test_sh();
    logic [31:0] sh_addr [2];
    logic [31:0] sh_exp  [2];
    sh_addr[0] = 32'h0000_0026; sh_exp[0] = 32'hBEEF_5555;
    sh_addr[1] = 32'h0000_0024; sh_exp[1] = 32'hAAAA_BEEF;
    for (int i = 0; i < 2; i++) begin
      poke(1'b0, 6'd9, 32'hAAAA_5555);
      issue1(2'b01, sh_addr[i], 32'h0000_BEEF);
      next_cycle();
      next_cycle();
      checks++; if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h24) begin failures++; $display("FAIL sh%0d_write_c3: got wr=%b addr=%h want 1 00000024", i, mem_wr1, mem_addr1); end
      checks++; if (mem_wdata1 !== sh_exp[i]) begin failures++; $display("FAIL sh%0d_wdata_c3: got %h want %h", i, mem_wdata1, sh_exp[i]); end
      next_cycle();
      checks++; if (done1 !== 1'b1 || misalign1 !== 1'b0) begin failures++; $display("FAIL sh%0d_done_c4: got done=%b mis=%b want 1 0", i, done1, misalign1); end
      next_cycle();
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  ty [3];
    logic [31:0] ad [3];
    int          wr0;
    ty[0] = 2'b01; ad[0] = 32'h0000_0023;
    ty[1] = 2'b00; ad[1] = 32'h0000_0022;
    ty[2] = 2'b11; ad[2] = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      wr0 = wr_cnt1;
      issue1(ty[i], ad[i], 32'h1234_5678);
      checks++; if (done1 !== 1'b1 || misalign1 !== 1'b1) begin failures++; $display("FAIL err%0d_c1: got done=%b mis=%b want 1 1", i, done1, misalign1); end
      checks++; if (mem_wr1 !== 1'b0 || mem_addr1 !== 32'd0 || busy1 !== 1'b1) begin failures++; $display("FAIL err%0d_mem_c1: got wr=%b addr=%h busy=%b want 0 0 1", i, mem_wr1, mem_addr1, busy1); end
      next_cycle();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || misalign1 !== 1'b0 || mem_wr1 !== 1'b0) begin failures++; $display("FAIL err%0d_c2: got busy=%b done=%b mis=%b wr=%b want 0 0 0 0", i, busy1, done1, misalign1, mem_wr1); end
      checks++; if (wr_cnt1 !== wr0) begin failures++; $display("FAIL err%0d_nowrite: got %0d writes want 0", i, wr_cnt1 - wr0); end
    end
  endtask

  task automatic test_back_to_back();
    int wr0;
    wr0 = wr_cnt1;
    issue1(2'b00, 32'h0000_0040, 32'h0123_4567);
    checks++; if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h40) begin failures++; $display("FAIL b2b_a_c1: got wr=%b addr=%h want 1 00000040", mem_wr1, mem_addr1); end
    next_cycle();
    // Raise the second request during the DONE cycle: it must be ignored on this edge.
    store_type = 2'b00; addr = 32'h0000_0044; write_data = 32'h89AB_CDEF; start1 = 1'b1;
    next_cycle();
    checks++; if (busy1 !== 1'b0 || mem_wr1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_c3: got busy=%b wr=%b want 0 0", busy1, mem_wr1); end
    next_cycle();
    start1 = 1'b0;
    checks++; if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h44 || mem_wdata1 !== 32'h89AB_CDEF) begin failures++; $display("FAIL b2b_b_c4: got wr=%b addr=%h data=%h want 1 00000044 89abcdef", mem_wr1, mem_addr1, mem_wdata1); end
    next_cycle();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL b2b_b_done: got %b want 1", done1); end
    next_cycle();
    checks++; if (wr_cnt1 !== wr0 + 2) begin failures++; $display("FAIL b2b_writes: got %0d want 2", wr_cnt1 - wr0); end
  endtask

  task automatic test_start_held();
    int          done_n, done_cyc, wr_n, wr_cyc, busy_n, wr0;
    logic [31:0] wr_data;
    done_n = 0; done_cyc = -1; wr_n = 0; wr_cyc = -1; busy_n = 0; wr_data = 32'd0;
    poke(1'b1, 6'd12, 32'h0102_0304);
    wr0 = wr_cnt3;
    store_type = 2'b10; addr = 32'h0000_0031; write_data = 32'h0000_0077; start3 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 7) start3 = 1'b0;
      if (busy3) busy_n++;
      if (done3) begin done_n++; done_cyc = c; end
      if (mem_wr3) begin wr_n++; wr_cyc = c; wr_data = mem_wdata3; end
    end
    checks++; if (done_n !== 1 || done_cyc !== 6) begin failures++; $display("FAIL held_done: got %0d pulses at cycle %0d want 1 at 6", done_n, done_cyc); end
    checks++; if (wr_n !== 1 || wr_cyc !== 5) begin failures++; $display("FAIL held_write: got %0d writes at cycle %0d want 1 at 5", wr_n, wr_cyc); end
    checks++; if (wr_data !== 32'h0102_7704) begin failures++; $display("FAIL held_wdata: got %h want 01027704", wr_data); end
    checks++; if (busy_n !== 6) begin failures++; $display("FAIL held_busy: got %0d busy cycles want 6", busy_n); end
    checks++; if (wr_cnt3 !== wr0 + 1 || mem3[12] !== 32'h0102_7704) begin failures++; $display("FAIL held_mem: got writes=%0d word=%h want 1 01027704", wr_cnt3 - wr0, mem3[12]); end
    store_type = 2'b11;
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_cnt1;
    // Abort during READ.
    issue1(2'b10, 32'h0000_0021, 32'h0000_0055);
    checks++; if (busy1 !== 1'b1 || mem_wr1 !== 1'b0) begin failures++; $display("FAIL rst_read_pre: got busy=%b wr=%b want 1 0", busy1, mem_wr1); end
    reset = 1'b1;
    #1;
    checks++; if (mem_wr1 !== 1'b0 || busy1 !== 1'b0 || mem_addr1 !== 32'd0) begin failures++; $display("FAIL rst_read_now: got wr=%b busy=%b addr=%h want 0 0 0", mem_wr1, busy1, mem_addr1); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) next_cycle();
    checks++; if (wr_cnt1 !== wr0 || busy1 !== 1'b0) begin failures++; $display("FAIL rst_read_after: got writes=%0d busy=%b want 0 0", wr_cnt1 - wr0, busy1); end
    // Abort during WRITE, before the write edge.
    issue1(2'b10, 32'h0000_0021, 32'h0000_0066);
    next_cycle();
    next_cycle();
    checks++; if (mem_wr1 !== 1'b1) begin failures++; $display("FAIL rst_write_pre: got wr=%b want 1", mem_wr1); end
    reset = 1'b1;
    #1;
    checks++; if (mem_wr1 !== 1'b0 || busy1 !== 1'b0 || mem_wdata1 !== 32'd0) begin failures++; $display("FAIL rst_write_now: got wr=%b busy=%b data=%h want 0 0 0", mem_wr1, busy1, mem_wdata1); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) next_cycle();
    checks++; if (wr_cnt1 !== wr0 || busy1 !== 1'b0) begin failures++; $display("FAIL rst_write_after: got writes=%0d busy=%b want 0 0", wr_cnt1 - wr0, busy1); end
    // A fresh sw after the aborts completes normally.
    issue1(2'b00, 32'h0000_0050, 32'hCAFE_F00D);
    checks++; if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h50 || mem_wdata1 !== 32'hCAFE_F00D) begin failures++; $display("FAIL rst_sw_c1: got wr=%b addr=%h data=%h want 1 00000050 cafef00d", mem_wr1, mem_addr1, mem_wdata1); end
    next_cycle();
    checks++; if (done1 !== 1'b1 || misalign1 !== 1'b0) begin failures++; $display("FAIL rst_sw_done: got done=%b mis=%b want 1 0", done1, misalign1); end
    next_cycle();
    checks++; if (wr_cnt1 !== wr0 + 1 || mem1[20] !== 32'hCAFE_F00D) begin failures++; $display("FAIL rst_sw_mem: got writes=%0d word=%h want 1 cafef00d", wr_cnt1 - wr0, mem1[20]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    store_type = 2'b00; addr = 32'd0; write_data = 32'd0;
    poke1 = 1'b0; poke3 = 1'b0; poke_idx = 6'd0; poke_val = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misalign();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
